// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : button_repeat
//  Description : Converts a debounced button level into press pulses (initial
//                press, first repeat after a hold delay, then periodic
//                auto-repeat) plus a release pulse. Timing is in tick strobes.
//                The release output is named release_pulse because "release"
//                is a reserved word in SystemVerilog.
//  Revision    : 1.0  initial release
// ============================================================================
module button_repeat #(
  parameter logic [15:0] HOLD_TICKS   = 16'd500,
  parameter logic [15:0] REPEAT_TICKS = 16'd100,
  parameter int          CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       in,
  output logic       press,
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] repeat_cnt
);

  // Terminal counts, resized once to the counter width.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 16'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 16'd1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // Saturating increment used for every repeat.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Press/hold/repeat state machine; all outputs registered, pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
      repeat_cnt    <= 8'd0;
      // Start high so a button held through reset is not seen as a new press.
      last          <= 1'b1;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      last          <= in;
      case (state)
        IDLE: begin
          if (in && !last) begin
            press      <= 1'b1;
            cnt        <= '0;
            repeat_cnt <= 8'd0;
            state      <= WAIT_HOLD;
          end
        end
        WAIT_HOLD: begin
          // Release is checked first so it wins over an expiring tick.
          if (!in) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
          end else if (tick) begin
            if (cnt == HOLD_LAST) begin
              press      <= 1'b1;
              held       <= 1'b1;
              repeat_cnt <= sat_inc(repeat_cnt);
              cnt        <= '0;
              state      <= REPEAT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!in) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            state         <= IDLE;
          end else if (tick) begin
            if (cnt == REPEAT_LAST) begin
              press      <= 1'b1;
              repeat_cnt <= sat_inc(repeat_cnt);
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          held  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_repeat
//  Description : Directed self-checking bench for button_repeat. Instance a
//                uses HOLD_TICKS=3, REPEAT_TICKS=2 with a tick every 4 clks;
//                instance b uses REPEAT_TICKS=1 with a tick every clk.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_repeat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_a, tick_a, in_b, tick_b;
  logic       press_a, release_a, held_a;
  logic       press_b, release_b, held_b;
  logic [7:0] rc_a, rc_b;

  int errors = 0;
  int checks = 0;
  int pa, ra, pb;
  bit held_seen;

  button_repeat #(.HOLD_TICKS(16'd3), .REPEAT_TICKS(16'd2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .tick(tick_a), .in(in_a),
    .press(press_a), .release_pulse(release_a), .held(held_a), .repeat_cnt(rc_a)
  );

  button_repeat #(.HOLD_TICKS(16'd3), .REPEAT_TICKS(16'd1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .in(in_b),
    .press(press_b), .release_pulse(release_b), .held(held_b), .repeat_cnt(rc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on negedge, sample 1 time unit after posedge.
  task automatic cyc(input logic ia, input logic ta, input logic ib, input logic tb);
    @(negedge clk);
    in_a = ia; tick_a = ta; in_b = ib; tick_b = tb;
    @(posedge clk);
    #1;
    pa += int'(press_a);
    ra += int'(release_a);
    pb += int'(press_b);
    if (held_a) held_seen = 1'b1;
  endtask

  // One tick period on instance a: three quiet clks, then the tick clk.
  task automatic period_a(input logic ia);
    cyc(ia, 1'b0, 1'b0, 1'b0);
    cyc(ia, 1'b0, 1'b0, 1'b0);
    cyc(ia, 1'b0, 1'b0, 1'b0);
    cyc(ia, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_a = 1'b1; tick_a = 1'b0; in_b = 1'b0; tick_b = 1'b0;
    pa = 0; ra = 0; pb = 0; held_seen = 1'b0;

    // 1: button held through reset gives no press until seen low once
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_press", press_a, 0);
    chk("rst_release", release_a, 0);
    chk("rst_held", held_a, 0);
    chk("rst_rc", rc_a, 0);
    rst = 1'b0;
    pa = 0;
    for (int k = 0; k < 10; k++) period_a(1'b1);
    chk("t1_no_press_held_through_reset", pa, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_low_no_press", press_a, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_press", press_a, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_press_one_clk", press_a, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_release", release_a, 1);
    chk("t1_release_no_press", press_a, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_release_one_clk", release_a, 0);

    // 2: short press of two ticks
    pa = 0; ra = 0; held_seen = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    period_a(1'b1);
    period_a(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_presses", pa, 1);
    chk("t2_releases", ra, 1);
    chk("t2_held_seen", held_seen, 0);
    chk("t2_rc", rc_a, 0);

    // 3: long hold through nine ticks
    pa = 0; ra = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_initial_press", press_a, 1);
    for (int k = 1; k <= 9; k++) begin
      period_a(1'b1);
      chk($sformatf("t3_press_tick%0d", k), press_a,
          (k == 3 || k == 5 || k == 7 || k == 9) ? 1 : 0);
      chk($sformatf("t3_held_tick%0d", k), held_a, (k >= 3) ? 1 : 0);
    end
    chk("t3_rc", rc_a, 4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_release", release_a, 1);
    chk("t3_held_drop", held_a, 0);
    chk("t3_presses", pa, 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_rc_kept", rc_a, 4);

    // 4: release coincides with the expiring third tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_rc_cleared", rc_a, 0);
    period_a(1'b1);
    period_a(1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_release", release_a, 1);
    chk("t4_press", press_a, 0);
    chk("t4_held", held_a, 0);
    chk("t4_rc", rc_a, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset while repeating
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) period_a(1'b1);
    chk("t6_rc_before", rc_a, 3);
    chk("t6_held_before", held_a, 1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_press", press_a, 0);
    chk("t6_release", release_a, 0);
    chk("t6_held", held_a, 0);
    chk("t6_rc", rc_a, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_no_release_after", release_a, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_idle_press", press_a, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 5: REPEAT_TICKS=1, tick every clk, 300 ticks of hold
    pb = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_initial_press", press_b, 1);
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      if (k == 260) chk("t5_press_late", press_b, 1);
    end
    chk("t5_presses", pb, 299);
    chk("t5_rc_sat", rc_b, 255);
    chk("t5_press_last", press_b, 1);
    chk("t5_held", held_b, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_release", release_b, 1);
    chk("t5_release_no_press", press_b, 0);
    chk("t5_rc_kept", rc_b, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
